// File: rtl/gru_pkg.sv
// Shared constants, state encoding and Q2.14 saturation helpers for the GRU
// hidden-state backward datapath.
package gru_pkg;

  localparam int DATABIT = 16;
  localparam int FRAC    = 14;

  localparam logic signed [DATABIT-1:0] ONE_Q = 16'sh4000;
  localparam logic signed [DATABIT-1:0] QMAX  = 16'sh7FFF;
  localparam logic signed [DATABIT-1:0] QMIN  = 16'sh8000;

  typedef enum logic [2:0] {IDLE, P0, P1, P2, DONE} state_t;

  // A one-bit-wider sum overflowed when its top two bits disagree.
  function automatic logic is_ovf(input logic signed [DATABIT:0] v);
    return v[DATABIT] != v[DATABIT-1];
  endfunction

  function automatic logic signed [DATABIT-1:0] sat_word(input logic signed [DATABIT:0] v);
    if (!is_ovf(v)) return v[DATABIT-1:0];
    return v[DATABIT] ? QMIN : QMAX;
  endfunction

endpackage

// File: rtl/gru_qmul.sv
// Combinational signed fixed-point multiply with round-half-up and saturation
// to the word range; sat flags a clipped result.
module gru_qmul
  import gru_pkg::*;
#(
  parameter int DATABIT = gru_pkg::DATABIT,
  parameter int FRAC    = gru_pkg::FRAC
) (
  input  logic signed [DATABIT-1:0] a,
  input  logic signed [DATABIT-1:0] b,
  output logic signed [DATABIT-1:0] y,
  output logic                      sat
);

  localparam int PW = 2 * DATABIT + 1;
  localparam logic signed [PW-1:0] HALF  = PW'(1) <<< (FRAC - 1);
  localparam logic signed [PW-1:0] Y_MAX = (PW'(1) <<< (DATABIT - 1)) - PW'(1);
  localparam logic signed [PW-1:0] Y_MIN = -(PW'(1) <<< (DATABIT - 1));

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;

  always_comb begin
    prod    = PW'(a) * PW'(b);
    shifted = (prod + HALF) >>> FRAC;
    y       = shifted[DATABIT-1:0];
    sat     = 1'b0;
    if (shifted > Y_MAX) begin
      y   = {1'b0, {(DATABIT-1){1'b1}}};
      sat = 1'b1;
    end else if (shifted < Y_MIN) begin
      y   = {1'b1, {(DATABIT-1){1'b0}}};
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/gru_gate_bwd.sv
// Backward pass of ht = zt*ht1 + (1-zt)*htb: one shared multiplier produces
// dzt, dht1 and dhtb over three cycles, with valid/ready on both sides.
module gru_gate_bwd
  import gru_pkg::*;
#(
  parameter int DATABIT = gru_pkg::DATABIT,
  parameter int FRAC    = gru_pkg::FRAC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATABIT-1:0] delta,
  input  logic [DATABIT-1:0] zt,
  input  logic [DATABIT-1:0] ht1,
  input  logic [DATABIT-1:0] htb,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATABIT-1:0] dzt,
  output logic [DATABIT-1:0] dht1,
  output logic [DATABIT-1:0] dhtb,
  output logic               out_sat
);

  state_t state;

  logic signed [DATABIT-1:0] delta_q, zt_q, diff_q, omz_q;
  logic signed [DATABIT:0]   diff_wide, omz_wide;
  logic signed [DATABIT-1:0] mul_b, mul_y;
  logic                      mul_sat;

  assign diff_wide = $signed({ht1[DATABIT-1], ht1}) - $signed({htb[DATABIT-1], htb});
  assign omz_wide  = $signed({ONE_Q[DATABIT-1], ONE_Q}) - $signed({zt[DATABIT-1], zt});

  // delta is always the left operand; the state picks which factor it meets.
  always_comb begin
    mul_b = diff_q;
    case (state)
      P1:      mul_b = zt_q;
      P2:      mul_b = omz_q;
      default: mul_b = diff_q;
    endcase
  end

  gru_qmul #(
    .DATABIT(DATABIT),
    .FRAC   (FRAC)
  ) u_qmul (
    .a  (delta_q),
    .b  (mul_b),
    .y  (mul_y),
    .sat(mul_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      delta_q   <= '0;
      zt_q      <= '0;
      diff_q    <= '0;
      omz_q     <= '0;
      dzt       <= '0;
      dht1      <= '0;
      dhtb      <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            delta_q  <= delta;
            zt_q     <= zt;
            diff_q   <= sat_word(diff_wide);
            omz_q    <= sat_word(omz_wide);
            out_sat  <= is_ovf(diff_wide) | is_ovf(omz_wide);
            in_ready <= 1'b0;
            state    <= P0;
          end
        end
        P0: begin
          dzt     <= mul_y;
          out_sat <= out_sat | mul_sat;
          state   <= P1;
        end
        P1: begin
          dht1    <= mul_y;
          out_sat <= out_sat | mul_sat;
          state   <= P2;
        end
        P2: begin
          dhtb      <= mul_y;
          out_sat   <= out_sat | mul_sat;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
